// File: rtl/weight_stream_ctrl_pkg.sv
// Shared types and defaults for the weight streamer: layer sizes, FSM encoding
// and the read-credit helper used by the controller.
package weight_stream_ctrl_pkg;

    localparam int KERN_S_11   = 9;
    localparam int COEFF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ws_state_t;

    // A new read may go out only if the word it returns is sure to find a slot.
    function automatic logic credit_ok(input logic [1:0] occ, input logic inflight);
        return ({1'b0, occ} + {2'b00, inflight}) <= 3'd1;
    endfunction

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry FIFO that absorbs the ROM read latency; head is a register so the
// stream data stays stable while the downstream is full.
module weight_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] tail;
    logic                  pop_ok;

    assign pop_ok = pop && (count != 2'd0);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_data;
                    end else if (count == 2'd1) begin
                        tail <= push_data;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                // Simultaneous push and pop leaves the count unchanged.
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_stream_ctrl.sv
// Sequencer that sweeps the weight ROM NUM_PASSES times per start and feeds
// the coefficients into an ap_fifo-style stream at up to one word per cycle.
module weight_stream_ctrl
    import weight_stream_ctrl_pkg::*;
#(
    parameter int   MEM_SIZE   = KERN_S_11,
    parameter int   DATA_WIDTH = COEFF_WIDTH,
    parameter int   NUM_PASSES = 1,
    localparam int  ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  start,
    output logic                  idle,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] weight_address,
    output logic                  weight_ce,
    input  logic [DATA_WIDTH-1:0] weight_q,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    localparam int                    PASS_W    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [PASS_W-1:0]     LAST_PASS = PASS_W'(NUM_PASSES - 1);

    ws_state_t             state;
    ws_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [PASS_W-1:0]     pass;
    logic                  rd_inflight;
    logic [1:0]            buf_count;
    logic [1:0]            occ;
    logic                  issue;
    logic                  last_read;

    // The word returning from the ROM is captured exactly one cycle after its read.
    weight_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid_buf (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .push      (rd_inflight),
        .push_data (weight_q),
        .pop       (output_V_write),
        .head      (output_V_din),
        .count     (buf_count)
    );

    always_comb begin
        output_V_write = (buf_count != 2'd0) && output_V_full_n;
        occ            = buf_count - {1'b0, output_V_write};
        issue          = (state == FETCH) && credit_ok(occ, rd_inflight);
        last_read      = issue && (addr == LAST_ADDR) && (pass == LAST_PASS);
        // Last word: nothing in flight and only one entry left, leaving this cycle.
        done           = (state == DRAIN) && output_V_write && (buf_count == 2'd1) && !rd_inflight;
        state_nxt      = state;
        case (state)
            IDLE:    if (start)     state_nxt = FETCH;
            FETCH:   if (last_read) state_nxt = DRAIN;
            DRAIN:   if (done)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign idle           = (state == IDLE);
    assign weight_ce      = issue;
    assign weight_address = addr;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state       <= IDLE;
            addr        <= '0;
            pass        <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= issue;
            if (issue) begin
                if (addr == LAST_ADDR) begin
                    addr <= '0;
                    pass <= (pass == LAST_PASS) ? '0 : pass + PASS_W'(1);
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl: a 4-word, 2-pass instance and a
// 2-word, 1-pass instance, each fed by a 1-cycle ROM returning addr+10.
`timescale 1ns/1ps
module tb_weight_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: MEM_SIZE=4, NUM_PASSES=2
    logic        start = 1'b0;
    logic        idle, done, ce, wr;
    logic [1:0]  addr;
    logic [15:0] q, din;
    logic        full_n = 1'b1;

    weight_stream_ctrl #(.MEM_SIZE(4), .DATA_WIDTH(16), .NUM_PASSES(2)) dut (
        .ap_clk          (clk),
        .ap_rst          (rst),
        .start           (start),
        .idle            (idle),
        .done            (done),
        .weight_address  (addr),
        .weight_ce       (ce),
        .weight_q        (q),
        .output_V_din    (din),
        .output_V_full_n (full_n),
        .output_V_write  (wr)
    );

    // ROM model; drives junk whenever no read was issued.
    always @(posedge clk) q <= ce ? (16'(addr) + 16'd10) : 16'hDEAD;

    // Second instance: MEM_SIZE=2, NUM_PASSES=1
    logic        start2 = 1'b0;
    logic        idle2, done2, ce2, wr2;
    logic [0:0]  addr2;
    logic [15:0] q2, din2;

    weight_stream_ctrl #(.MEM_SIZE(2), .DATA_WIDTH(16), .NUM_PASSES(1)) dut2 (
        .ap_clk          (clk),
        .ap_rst          (rst),
        .start           (start2),
        .idle            (idle2),
        .done            (done2),
        .weight_address  (addr2),
        .weight_ce       (ce2),
        .weight_q        (q2),
        .output_V_din    (din2),
        .output_V_full_n (1'b1),
        .output_V_write  (wr2)
    );

    always @(posedge clk) q2 <= ce2 ? (16'(addr2) + 16'd10) : 16'hBEEF;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Port monitors, sampled on the falling edge.
    logic [15:0] wlog[$];
    int          wcyc[$];
    int          done_cnt = 0, done_cyc = -1, ce_cnt = 0, ovf = 0, tb_cnt = 0;
    logic        ce_d = 1'b0;
    logic [15:0] wlog2[$];
    int          wcyc2[$];
    int          done2_cnt = 0, done2_cyc = -1;

    always @(negedge clk) begin
        if (rst) begin
            tb_cnt = 0;
            ce_d   = 1'b0;
        end else begin
            if (wr) begin
                wlog.push_back(din);
                wcyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ce) ce_cnt++;
            if (ce_d && tb_cnt == 2 && !wr) ovf++;
            tb_cnt = tb_cnt + int'(ce_d) - int'(wr);
            ce_d   = ce;
            if (wr2) begin
                wlog2.push_back(din2);
                wcyc2.push_back(cyc);
            end
            if (done2) begin
                done2_cnt++;
                done2_cyc = cyc;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int st_cyc, st2_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start  = 1'b1;
        st_cyc = cyc;
        tick();
        start  = 1'b0;
    endtask

    task automatic clear_log();
        wlog.delete();
        wcyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        ce_cnt   = 0;
        ovf      = 0;
    endtask

    // Expected run: first..first+n-1 hold 10,11,12,13 repeating.
    task automatic check_words(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (first + i < wlog.size()) ? 32'(wlog[first + i]) : 32'hFFFF_FFFF,
                  32'(10 + (i % 4)));
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_idle", idle, 1);
        check("rst_ce", ce, 0);
        check("rst_write", wr, 0);
        check("rst_din", din, 0);
        check("rst_addr", addr, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick(2);

        // 1: free-running stream
        clear_log();
        pulse_start();
        tick(9);
        check("t1_done_pulse", done, 1);
        check("t1_idle_busy", idle, 0);
        tick();
        check("t1_idle_back", idle, 1);
        tick(4);
        check("t1_count", wlog.size(), 8);
        check_words("t1", 0, 8);
        check("t1_first_cyc", (wcyc.size() > 0) ? wcyc[0] : -1, st_cyc + 3);
        check("t1_last_cyc", (wcyc.size() > 7) ? wcyc[7] : -1, st_cyc + 10);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_cyc", done_cyc, st_cyc + 10);

        // 2: downstream full for cycles 1..10 after start
        clear_log();
        pulse_start();
        full_n = 1'b0;
        tick(4);
        check("t2_din_hold_a", din, 10);
        check("t2_reads_a", ce_cnt, 2);
        tick(5);
        check("t2_din_hold_b", din, 10);
        check("t2_reads_b", ce_cnt, 2);
        check("t2_no_write", wlog.size(), 0);
        tick();
        full_n = 1'b1;
        tick(12);
        check("t2_count", wlog.size(), 8);
        check_words("t2", 0, 8);
        check("t2_first_cyc", (wcyc.size() > 0) ? wcyc[0] : -1, st_cyc + 11);
        check("t2_done_cnt", done_cnt, 1);

        // 3: full_n toggling every cycle
        clear_log();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            full_n = ~full_n;
            tick();
        end
        full_n = 1'b1;
        tick(2);
        check("t3_count", wlog.size(), 8);
        check_words("t3", 0, 8);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_no_overflow", ovf, 0);

        // 4: starts while busy are ignored; start right after done is taken
        clear_log();
        pulse_start();
        tick(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(4);
        check("t4_done_cycle", done, 1);
        check("t4_busy_on_done", idle, 0);
        start = 1'b1;
        tick();
        check("t4_idle_after", idle, 1);
        st2_cyc = cyc;
        tick();
        start = 1'b0;
        check("t4_run1_count", wlog.size(), 8);
        check("t4_run1_done", done_cnt, 1);
        tick(14);
        check("t4_total_count", wlog.size(), 16);
        check_words("t4_run1", 0, 8);
        check_words("t4_run2", 8, 8);
        check("t4_run2_first", (wcyc.size() > 8) ? wcyc[8] : -1, st2_cyc + 3);
        check("t4_done_cnt", done_cnt, 2);

        // 5: reset after the 5th write
        clear_log();
        pulse_start();
        tick(7);
        check("t5_pre_count", wlog.size(), 5);
        rst = 1'b1;
        #1;
        check("t5_write", wr, 0);
        check("t5_din", din, 0);
        check("t5_ce", ce, 0);
        check("t5_idle", idle, 1);
        check("t5_addr", addr, 0);
        check("t5_done", done, 0);
        tick();
        rst = 1'b0;
        tick(6);
        check("t5_no_more_writes", wlog.size(), 5);
        check("t5_no_done", done_cnt, 0);
        clear_log();
        pulse_start();
        tick(14);
        check("t5_rerun_count", wlog.size(), 8);
        check_words("t5_rerun", 0, 8);

        // 6: MEM_SIZE=2, NUM_PASSES=1
        start2  = 1'b1;
        st2_cyc = cyc;
        tick();
        start2  = 1'b0;
        tick(8);
        check("t6_count", wlog2.size(), 2);
        check("t6_w0", (wlog2.size() > 0) ? 32'(wlog2[0]) : 32'hFFFF_FFFF, 10);
        check("t6_w1", (wlog2.size() > 1) ? 32'(wlog2[1]) : 32'hFFFF_FFFF, 11);
        check("t6_first_cyc", (wcyc2.size() > 0) ? wcyc2[0] : -1, st2_cyc + 3);
        check("t6_done_cnt", done2_cnt, 1);
        check("t6_done_cyc", done2_cyc, (wcyc2.size() > 1) ? wcyc2[1] : -2);
        check("t6_idle", idle2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
